// File: rtl/seg_scan_ctrl_if.sv
// Host-side bundle for seg_scan_ctrl: display update inputs plus scan and status outputs.
// master = whoever issues updates, slave = the scan controller.
interface seg_scan_ctrl_if #(
  parameter int unsigned DIGITS = 5
);
  logic [8*DIGITS-1:0] data_in;
  logic [1:0]          mode_in;
  logic [2:0]          cursor_in;
  logic                load;
  logic [DIGITS-1:0]   seg_select;
  logic [7:0]          seg_out;
  logic                frame_start;
  logic [2:0]          flash_cnt;
  logic                busy;

  modport master (
    output data_in, mode_in, cursor_in, load,
    input  seg_select, seg_out, frame_start, flash_cnt, busy
  );

  modport slave (
    input  data_in, mode_in, cursor_in, load,
    output seg_select, seg_out, frame_start, flash_cnt, busy
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with tear-free updates and flash modes.
// Optional SEG_GHOST_BLANK_EN: blank the first BLANK_TICKS cycles of every digit.
module seg_scan_ctrl #(
  parameter int unsigned DIGITS       = 5,
  parameter int unsigned DIGIT_TICKS  = 20000,
  parameter int unsigned FLASH_FRAMES = 100,
  parameter int unsigned BLANK_TICKS  = 200
) (
  input  logic           clk,
  input  logic           reset,
  seg_scan_ctrl_if.slave bus
);

  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned TW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam int unsigned FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
`ifdef SEG_GHOST_BLANK_EN
  localparam bit GHOST_BLANK = 1'b1;
`else
  localparam bit GHOST_BLANK = 1'b0;
`endif

  typedef enum logic [1:0] {
    MODE_CONST  = 2'd0,
    MODE_FLASH  = 2'd1,
    MODE_CURSOR = 2'd2,
    MODE_BLANK  = 2'd3
  } mode_e;

  typedef enum logic {
    PHASE_ON  = 1'b0,
    PHASE_OFF = 1'b1
  } phase_e;

  typedef struct packed {
    logic [8*DIGITS-1:0] data;
    mode_e               mode;
    logic [2:0]          cursor;
  } cfg_t;

  localparam cfg_t CFG_RESET = '{data: '0, mode: MODE_BLANK, cursor: '0};

  logic [TW-1:0]     tick_q, tick_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [FW-1:0]     frm_q, frm_d;
  phase_e            phase_q, phase_d;
  logic [2:0]        flash_cnt_q, flash_cnt_d;
  cfg_t              pend_q, pend_d;
  cfg_t              shadow_q, shadow_d;
  logic              pend_valid_q, pend_valid_d;
  logic [DIGITS-1:0] seg_select_q, seg_select_d;
  logic [7:0]        seg_out_q, seg_out_d;
  logic              frame_start_q, frame_start_d;

  logic              tick_wrap, boundary, apply, mode_change, flashing;
  logic              dark, blank;
  logic [DIGITS-1:0] sel_onehot;
  logic [7:0]        seg_raw;

  // Scan counters, pending/shadow update and flash timing.
  // NOTE: every signal written here gets its default first, so no path can infer a latch.
  always_comb begin
    tick_wrap   = (tick_q == TW'(DIGIT_TICKS - 1));
    boundary    = tick_wrap && (idx_q == IW'(DIGITS - 1));
    apply       = boundary && pend_valid_q;
    mode_change = apply && (pend_q.mode != shadow_q.mode);
    flashing    = (shadow_q.mode == MODE_FLASH) || (shadow_q.mode == MODE_CURSOR);

    tick_d       = tick_wrap ? '0 : tick_q + TW'(1);
    idx_d        = idx_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    shadow_d     = shadow_q;
    frm_d        = frm_q;
    phase_d      = phase_q;
    flash_cnt_d  = flash_cnt_q;

    if (tick_wrap) begin
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end

    if (apply) begin
      shadow_d     = pend_q;
      pend_valid_d = 1'b0;
    end
    // A load on the boundary cycle lands in the pending buffer after the swap above.
    if (bus.load) begin
      pend_d       = '{data: bus.data_in, mode: mode_e'(bus.mode_in), cursor: bus.cursor_in};
      pend_valid_d = 1'b1;
    end

    if (boundary) begin
      if (mode_change) begin
        frm_d       = '0;
        phase_d     = PHASE_ON;
        flash_cnt_d = '0;
      end else if (frm_q == FW'(FLASH_FRAMES - 1)) begin
        frm_d   = '0;
        phase_d = (phase_q == PHASE_ON) ? PHASE_OFF : PHASE_ON;
        if ((phase_q == PHASE_OFF) && flashing && (flash_cnt_q != 3'd7)) begin
          flash_cnt_d = flash_cnt_q + 3'd1;
        end
      end else begin
        frm_d = frm_q + FW'(1);
      end
    end
  end

  // Next-cycle digit drive, gated by mode, flash phase and ghost blanking.
  always_comb begin
    sel_onehot = '0;
    seg_raw    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        sel_onehot[i] = 1'b1;
        seg_raw       = shadow_q.data[8*(DIGITS-1-i) +: 8];
      end
    end

    dark = (phase_q == PHASE_OFF) &&
           ((shadow_q.mode == MODE_FLASH) ||
            ((shadow_q.mode == MODE_CURSOR) && (32'(idx_q) == 32'(shadow_q.cursor))));
    blank = GHOST_BLANK && (32'(tick_q) < BLANK_TICKS);

    seg_select_d = '0;
    seg_out_d    = '0;
    if ((shadow_q.mode != MODE_BLANK) && !blank) begin
      seg_select_d = sel_onehot;
      seg_out_d    = dark ? 8'h00 : seg_raw;
    end
    frame_start_d = (idx_q == '0) && (tick_q == '0);
  end

  // NOTE: the wide shadow and pending registers are reset too, so the panel comes up blank.
  // NOTE: clocked state uses non-blocking assignments only; the comb blocks above use blocking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_q        <= '0;
      idx_q         <= '0;
      frm_q         <= '0;
      phase_q       <= PHASE_ON;
      flash_cnt_q   <= '0;
      pend_q        <= CFG_RESET;
      pend_valid_q  <= 1'b0;
      shadow_q      <= CFG_RESET;
      seg_select_q  <= '0;
      seg_out_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      tick_q        <= tick_d;
      idx_q         <= idx_d;
      frm_q         <= frm_d;
      phase_q       <= phase_d;
      flash_cnt_q   <= flash_cnt_d;
      pend_q        <= pend_d;
      pend_valid_q  <= pend_valid_d;
      shadow_q      <= shadow_d;
      seg_select_q  <= seg_select_d;
      seg_out_q     <= seg_out_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.seg_select  = seg_select_q;
  assign bus.seg_out     = seg_out_q;
  assign bus.frame_start = frame_start_q;
  assign bus.flash_cnt   = flash_cnt_q;
  assign bus.busy        = pend_valid_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with shortened timing: 4 clk per digit, 2 frames per flash half-period.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_seg_scan_ctrl;
  localparam int unsigned DIGITS       = 5;
  localparam int unsigned DIGIT_TICKS  = 4;
  localparam int unsigned FLASH_FRAMES = 2;
  localparam int unsigned BLANK_TICKS  = 1;
  localparam int unsigned FRAME        = DIGITS * DIGIT_TICKS;
`ifdef SEG_GHOST_BLANK_EN
  localparam bit GHOST = 1'b1;
`else
  localparam bit GHOST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [39:0] D1 = 40'h3F_06_5B_4F_66;
  logic [39:0] DA = 40'h11_22_33_44_55;
  logic [39:0] DB = 40'h6D_7D_07_7F_6F;
  logic [39:0] DC = 40'h5E_79_71_3D_76;
  logic [7:0]  exp1 [5] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66};

  seg_scan_ctrl_if #(.DIGITS(DIGITS)) bus ();

  seg_scan_ctrl #(
    .DIGITS(DIGITS), .DIGIT_TICKS(DIGIT_TICKS),
    .FLASH_FRAMES(FLASH_FRAMES), .BLANK_TICKS(BLANK_TICKS)
  ) dut (
    .clk(clk), .reset(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got no finish exp finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

  // Leftmost digit 0 lives in the top byte.
  function automatic logic [7:0] byte_of(input logic [39:0] data, input int d);
    return data[8*(4-d) +: 8];
  endfunction

  task automatic wait_frame(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 3*FRAME && !seen; i++) begin
      @(negedge clk);
      seen = (bus.frame_start === 1'b1);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL %s_frame_wait got no frame_start exp pulse within %0d clk", tag, 3*FRAME); end
  endtask

  task automatic do_load(input logic [39:0] data, input logic [1:0] mode, input logic [2:0] cursor);
    bus.data_in = data; bus.mode_in = mode; bus.cursor_in = cursor; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.load = 1'b0; bus.data_in = '0; bus.mode_in = 2'd0; bus.cursor_in = 3'd0;
    repeat (3) @(negedge clk);
    checks++; if (bus.seg_select !== 5'b0) begin errors++; $display("FAIL reset_sel got %b exp 00000", bus.seg_select); end
    checks++; if (bus.seg_out !== 8'h00) begin errors++; $display("FAIL reset_seg got %h exp 00", bus.seg_out); end
    checks++; if (bus.frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs got %b exp 0", bus.frame_start); end
    checks++; if (bus.flash_cnt !== 3'd0) begin errors++; $display("FAIL reset_fc got %0d exp 0", bus.flash_cnt); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.frame_start !== 1'b1) begin errors++; $display("FAIL reset_first_fs got %b exp 1", bus.frame_start); end
    @(negedge clk);
    checks++; if (bus.frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs_pulse got %b exp 0", bus.frame_start); end
    repeat (8) @(negedge clk);
    checks++; if (bus.seg_select !== 5'b0) begin errors++; $display("FAIL reset_blank_sel got %b exp 00000", bus.seg_select); end
  endtask

  task automatic test_scan();
    wait_frame("scan_sync");
    do_load(D1, 2'd0, 3'd0);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL scan_busy got %b exp 1", bus.busy); end
    wait_frame("scan");
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL scan_busy_clr got %b exp 0", bus.busy); end
    for (int n = 0; n < FRAME; n++) begin
      int d = n / DIGIT_TICKS;
      int t = n % DIGIT_TICKS;
      logic [4:0] es;
      logic [7:0] eo;
      if (n > 0) @(negedge clk);
      es = (GHOST && t < BLANK_TICKS) ? 5'b0 : (5'b00001 << d);
      eo = (GHOST && t < BLANK_TICKS) ? 8'h00 : exp1[d];
      checks++; if (bus.seg_select !== es) begin errors++; $display("FAIL scan_sel n=%0d got %b exp %b", n, bus.seg_select, es); end
      checks++; if (bus.seg_out !== eo) begin errors++; $display("FAIL scan_seg n=%0d got %h exp %h", n, bus.seg_out, eo); end
      checks++; if (bus.frame_start !== (n == 0)) begin errors++; $display("FAIL scan_fs n=%0d got %b exp %b", n, bus.frame_start, n == 0); end
    end
  endtask

  task automatic test_flash();
    wait_frame("flash_sync");
    do_load(D1, 2'd1, 3'd0);
    for (int f = 0; f < 36; f++) begin
      logic [7:0] eo;
      logic [2:0] ec;
      wait_frame("flash");
      @(negedge clk);
      eo = ((f % 4) < 2) ? 8'h3F : 8'h00;
      ec = (f / 4 > 7) ? 3'd7 : 3'(f / 4);
      checks++; if (bus.seg_select !== 5'b00001) begin errors++; $display("FAIL flash_sel f=%0d got %b exp 00001", f, bus.seg_select); end
      checks++; if (bus.seg_out !== eo) begin errors++; $display("FAIL flash_seg f=%0d got %h exp %h", f, bus.seg_out, eo); end
      checks++; if (bus.flash_cnt !== ec) begin errors++; $display("FAIL flash_cnt f=%0d got %0d exp %0d", f, bus.flash_cnt, ec); end
    end
  endtask

  task automatic test_cursor();
    wait_frame("cursor_sync");
    do_load(D1, 2'd2, 3'd2);
    wait_frame("cursor_f0");
    @(negedge clk);
    checks++; if (bus.flash_cnt !== 3'd0) begin errors++; $display("FAIL cursor_fc_clear got %0d exp 0", bus.flash_cnt); end
    repeat (8) @(negedge clk);
    checks++; if (bus.seg_out !== 8'h5B) begin errors++; $display("FAIL cursor_on_d2 got %h exp 5b", bus.seg_out); end
    wait_frame("cursor_f1");
    wait_frame("cursor_f2");
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      if (n % DIGIT_TICKS == 1) begin
        int d = n / DIGIT_TICKS;
        logic [7:0] eo = (d == 2) ? 8'h00 : exp1[d];
        checks++; if (bus.seg_select !== (5'b00001 << d)) begin errors++; $display("FAIL cursor_sel d=%0d got %b exp %b", d, bus.seg_select, 5'b00001 << d); end
        checks++; if (bus.seg_out !== eo) begin errors++; $display("FAIL cursor2_seg d=%0d got %h exp %h", d, bus.seg_out, eo); end
      end
    end
    do_load(D1, 2'd2, 3'd5);
    wait_frame("cursor_f3");
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      if (n % DIGIT_TICKS == 1) begin
        int d = n / DIGIT_TICKS;
        checks++; if (bus.seg_out !== exp1[d]) begin errors++; $display("FAIL cursor5_seg d=%0d got %h exp %h", d, bus.seg_out, exp1[d]); end
      end
    end
    wait_frame("cursor_f4");
    @(negedge clk);
    checks++; if (bus.flash_cnt !== 3'd1) begin errors++; $display("FAIL cursor_same_mode_fc got %0d exp 1", bus.flash_cnt); end
  endtask

  task automatic test_back_to_back();
    wait_frame("b2b_sync");
    do_load(DA, 2'd0, 3'd0);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_first got %b exp 1", bus.busy); end
    do_load(DB, 2'd0, 3'd0);
    for (int n = 2; n <= 18; n++) begin
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy n=%0d got %b exp 1", n, bus.busy); end
      @(negedge clk);
    end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_clr got %b exp 0", bus.busy); end
    checks++; if (bus.seg_out !== 8'h66) begin errors++; $display("FAIL b2b_no_tear got %h exp 66", bus.seg_out); end
    @(negedge clk);
    checks++; if (bus.frame_start !== 1'b1) begin errors++; $display("FAIL b2b_fs got %b exp 1", bus.frame_start); end
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      if (n % DIGIT_TICKS == 1) begin
        int d = n / DIGIT_TICKS;
        checks++; if (bus.seg_out !== byte_of(DB, d)) begin errors++; $display("FAIL b2b_seg d=%0d got %h exp %h", d, bus.seg_out, byte_of(DB, d)); end
      end
    end
  endtask

  task automatic test_boundary_load();
    wait_frame("bnd_sync");
    repeat (18) @(negedge clk);
    do_load(DC, 2'd0, 3'd0);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL bnd_busy got %b exp 1", bus.busy); end
    @(negedge clk);
    checks++; if (bus.frame_start !== 1'b1) begin errors++; $display("FAIL bnd_fs got %b exp 1", bus.frame_start); end
    @(negedge clk);
    checks++; if (bus.seg_out !== byte_of(DB, 0)) begin errors++; $display("FAIL bnd_deferred got %h exp %h", bus.seg_out, byte_of(DB, 0)); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL bnd_busy_hold got %b exp 1", bus.busy); end
    wait_frame("bnd_apply");
    @(negedge clk);
    checks++; if (bus.seg_out !== byte_of(DC, 0)) begin errors++; $display("FAIL bnd_applied got %h exp %h", bus.seg_out, byte_of(DC, 0)); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL bnd_busy_clr got %b exp 0", bus.busy); end

    // Mode 1 -> 0 -> 1 restarts the flash timeline and count.
    wait_frame("mode_sync");
    do_load(DC, 2'd1, 3'd0);
    for (int f = 0; f <= 4; f++) begin
      logic [7:0] eo;
      wait_frame("mode_m1");
      @(negedge clk);
      eo = ((f % 4) < 2) ? byte_of(DC, 0) : 8'h00;
      checks++; if (bus.seg_out !== eo) begin errors++; $display("FAIL mode_m1_seg f=%0d got %h exp %h", f, bus.seg_out, eo); end
      checks++; if (bus.flash_cnt !== 3'(f / 4)) begin errors++; $display("FAIL mode_m1_fc f=%0d got %0d exp %0d", f, bus.flash_cnt, f / 4); end
    end
    do_load(DC, 2'd0, 3'd0);
    wait_frame("mode_m0");
    @(negedge clk);
    checks++; if (bus.flash_cnt !== 3'd0) begin errors++; $display("FAIL mode_m0_fc got %0d exp 0", bus.flash_cnt); end
    do_load(DC, 2'd1, 3'd0);
    wait_frame("mode_m1b");
    @(negedge clk);
    checks++; if (bus.seg_out !== byte_of(DC, 0)) begin errors++; $display("FAIL mode_phase_on got %h exp %h", bus.seg_out, byte_of(DC, 0)); end
    checks++; if (bus.flash_cnt !== 3'd0) begin errors++; $display("FAIL mode_m1b_fc got %0d exp 0", bus.flash_cnt); end
  endtask

  task automatic test_reset_mid();
    wait_frame("rst_sync");
    do_load(DA, 2'd0, 3'd0);
    repeat (5) @(negedge clk);
    checks++; if (bus.seg_select !== 5'b00010) begin errors++; $display("FAIL rst_pre_sel got %b exp 00010", bus.seg_select); end
    checks++; if (bus.seg_out !== byte_of(DC, 1)) begin errors++; $display("FAIL rst_pre_seg got %h exp %h", bus.seg_out, byte_of(DC, 1)); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got %b exp 1", bus.busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.seg_select !== 5'b0) begin errors++; $display("FAIL rst_async_sel got %b exp 00000", bus.seg_select); end
    checks++; if (bus.seg_out !== 8'h00) begin errors++; $display("FAIL rst_async_seg got %h exp 00", bus.seg_out); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy got %b exp 0", bus.busy); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.frame_start !== 1'b1) begin errors++; $display("FAIL rst_restart_fs got %b exp 1", bus.frame_start); end
    checks++; if (bus.seg_select !== 5'b0) begin errors++; $display("FAIL rst_restart_blank got %b exp 00000", bus.seg_select); end
    do_load(DA, 2'd0, 3'd0);
    wait_frame("rst_apply");
    @(negedge clk);
    checks++; if (bus.seg_select !== 5'b00001) begin errors++; $display("FAIL rst_digit0_sel got %b exp 00001", bus.seg_select); end
    checks++; if (bus.seg_out !== byte_of(DA, 0)) begin errors++; $display("FAIL rst_digit0_seg got %h exp %h", bus.seg_out, byte_of(DA, 0)); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_flash();
    test_cursor();
    test_back_to_back();
    test_boundary_load();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
